chimera_mem_to_reg: RTL and testbench
=====================================

CHIMERA_MEM_TO_REG -- requirements
Module: chimera_mem_to_reg

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: width of the mem-side address.
REQ-002 SHALL have parameter DataWidth, default 32: width of the mem-side data; wstrb is DataWidth/8.
REQ-003 SHALL have parameter TimeoutCycles, default 256: cycles waited for the reg response before aborting; 0 disables the timeout.
REQ-004 SHALL have type parameters reg_req_t and reg_rsp_t, default logic: regbus request and response structs.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port req_i, input, 1 bit: mem request.
REQ-008 SHALL have port gnt_o, output, 1 bit: mem grant.
REQ-009 SHALL have port we_i, input, 1 bit: write enable.
REQ-010 SHALL have port addr_i, input, AddrWidth bits: address.
REQ-011 SHALL have port wdata_i, input, DataWidth bits: write data.
REQ-012 SHALL have port wstrb_i, input, DataWidth/8 bits: byte strobes.
REQ-013 SHALL have port rvalid_o, output, 1 bit: response valid, one-cycle pulse.
REQ-014 SHALL have port rdata_o, output, DataWidth bits: read data.
REQ-015 SHALL have port rerror_o, output, 1 bit: error qualifier for rvalid_o.
REQ-016 SHALL have port reg_req_o, output, reg_req_t: regbus request (valid, write, addr, wdata, wstrb).
REQ-017 SHALL have port reg_rsp_i, input, reg_rsp_t: regbus response (ready, rdata, error).
REQ-018 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when an access is aborted.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-020 SHALL assert gnt_o = req_i combinationally in IDLE and RESP, and drive gnt_o = 0 in ACCESS.
REQ-021 SHALL, on req_i && gnt_o, register we_i, addr_i, wdata_i and wstrb_i, then enter ACCESS in the next cycle.
REQ-022 SHALL in ACCESS drive reg_req_o.valid = 1 and hold the registered fields stable until the access ends.
REQ-023 SHALL drive reg_req_o.valid = 0 and all other reg_req_o fields to '0 outside ACCESS.
REQ-024 SHALL, in an ACCESS cycle with reg_rsp_i.ready = 1, capture rdata (reads only, '0 for writes) and error, then enter RESP.
REQ-025 SHALL in RESP assert rvalid_o = 1 for exactly one cycle, for reads and writes, with rdata_o and rerror_o from the captured values.
REQ-026 SHALL drive rdata_o and rerror_o to 0 whenever rvalid_o = 0.
REQ-027 SHALL, on a grant in RESP, go to ACCESS; otherwise RESP SHALL go to IDLE.
REQ-028 SHALL have minimum latency of grant at cycle 0, reg valid at cycle 1, rvalid at cycle 2 (ready in cycle 1), with back-to-back throughput of one access per 2 cycles.
REQ-029 SHALL count cycles in ACCESS with a counter of width $clog2(TimeoutCycles+1), cleared on entry to ACCESS.
REQ-030 SHALL treat the access as aborted when the counter reaches TimeoutCycles-1 with ready = 0: drop valid, pulse timeout_o, and enter RESP with rerror = 1 and rdata = '0.
REQ-031 SHALL give ready priority over timeout when both occur in the same cycle.
REQ-032 SHALL, when TimeoutCycles = 0, never abort and never assert timeout_o.
REQ-033 SHALL ignore reg_rsp_i.ready outside ACCESS.

Reset
REQ-034 SHALL on rst_ni low asynchronously enter IDLE and clear the counter, captured data, registered request and all outputs (gnt_o follows req_i in IDLE).
REQ-035 SHALL on reset mid-ACCESS drop reg_req_o.valid immediately, with no rvalid_o for the lost access.

Structure
REQ-036 SHALL place the default timeout constant RegBridgeTimeoutCycles in chimera_pkg.
REQ-037 SHALL keep the FSM state enum local to the module.
REQ-038 SHALL not contain sub-modules; the counter is inline.

Verification
REQ-039 SHALL cover: read addr 0x100, ready at cycle 1 with rdata 0xDEADBEEF -> rvalid at cycle 2, rdata 0xDEADBEEF, rerror 0.
REQ-040 SHALL cover: write 0xCAFEF00D, wstrb 0xF, ready after 3 wait cycles -> reg fields stable for 4 cycles, then one rvalid pulse with rerror 0.
REQ-041 SHALL cover: TimeoutCycles = 4 with ready never asserted -> valid for 4 cycles, timeout_o pulse, rvalid with rerror 1 and rdata 0.
REQ-042 SHALL cover: req_i held high for 3 reads with ready immediate -> grants at cycles 0, 2, 4 and rvalids at cycles 2, 4, 6.
REQ-043 SHALL cover: ready and timeout in the same cycle -> normal response, rerror = reg error, no timeout_o.
REQ-044 SHALL cover: rst_ni low during ACCESS -> valid low asynchronously, no rvalid, and a new request after reset completes normally.

Source files
------------

// File: rtl/chimera_pkg.sv
// chimera_pkg: shared regbus types and default bridge timeout.
package chimera_pkg;

   localparam int unsigned RegBridgeTimeoutCycles = 256;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } reg_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        error;
   } reg_rsp_t;

endpackage

// File: rtl/chimera_mem_to_reg_if.sv
// chimera_mem_to_reg_if: mem-side request/response bundle of the mem-to-regbus bridge.
interface chimera_mem_to_reg_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   logic                   req;
   logic                   gnt;
   logic                   we;
   logic [AddrWidth-1:0]   addr;
   logic [DataWidth-1:0]   wdata;
   logic [DataWidth/8-1:0] wstrb;
   logic                   rvalid;
   logic [DataWidth-1:0]   rdata;
   logic                   rerror;

   modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata, rerror);
   modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata, rerror);
endinterface

// File: rtl/chimera_mem_to_reg.sv
// chimera_mem_to_reg: bridges a mem-style req/gnt/rvalid port onto a single-outstanding regbus
// access, with an optional timeout that turns a hung access into an error response.
module chimera_mem_to_reg #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = chimera_pkg::RegBridgeTimeoutCycles,
   parameter type         reg_req_t     = chimera_pkg::reg_req_t,
   parameter type         reg_rsp_t     = chimera_pkg::reg_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic                   we_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] wstrb_i,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   rerror_o,
   output reg_req_t               reg_req_o,
   input  reg_rsp_t               reg_rsp_i,
   output logic                   timeout_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   state_e                 r_state;
   logic [CntW-1:0]        r_cnt;
   logic                   r_we;
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_wdata;
   logic [DataWidth/8-1:0] r_wstrb;
   logic [DataWidth-1:0]   r_rdata;
   logic                   r_rerror;
   logic                   r_rvalid;
   logic                   r_timeout;
   logic                   w_access;
   logic                   w_abort;

   assign w_access = (r_state == ACCESS);
   assign gnt_o    = req_i && !w_access;
   // ready is checked first in the FSM, so a late ready still wins over the abort
   assign w_abort  = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles - 1)) && !reg_rsp_i.ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_rerror  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_rvalid  <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            IDLE, RESP: begin
               if (req_i) begin
                  r_we    <= we_i;
                  r_addr  <= addr_i;
                  r_wdata <= wdata_i;
                  r_wstrb <= wstrb_i;
                  r_cnt   <= '0;
                  r_state <= ACCESS;
               end else begin
                  r_state <= IDLE;
               end
            end
            ACCESS: begin
               if (reg_rsp_i.ready) begin
                  r_rdata  <= r_we ? '0 : reg_rsp_i.rdata;
                  r_rerror <= reg_rsp_i.error;
                  r_rvalid <= 1'b1;
                  r_state  <= RESP;
               end else if (w_abort) begin
                  r_rdata   <= '0;
                  r_rerror  <= 1'b1;
                  r_rvalid  <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      reg_req_o = '0;
      if (w_access) begin
         reg_req_o.valid = 1'b1;
         reg_req_o.write = r_we;
         reg_req_o.addr  = r_addr;
         reg_req_o.wdata = r_wdata;
         reg_req_o.wstrb = r_wstrb;
      end
   end

   assign rvalid_o  = r_rvalid;
   assign rdata_o   = r_rvalid ? r_rdata : '0;
   assign rerror_o  = r_rvalid && r_rerror;
   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_chimera_mem_to_reg.sv
// tb_chimera_mem_to_reg: two bridges (timeout 4 and timeout disabled) share one random stimulus
// stream and are checked every cycle against a transaction-level model, plus directed scenarios.
module tb_chimera_mem_to_reg;
   import chimera_pkg::*;

   localparam int T0 = 4;
   localparam int T1 = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chimera_mem_to_reg_if m0 ();
   chimera_mem_to_reg_if m1 ();
   reg_req_t q0, q1;
   reg_rsp_t rsp;
   logic     to0, to1;

   chimera_mem_to_reg #(.TimeoutCycles(T0)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(m0.req), .gnt_o(m0.gnt), .we_i(m0.we),
      .addr_i(m0.addr), .wdata_i(m0.wdata), .wstrb_i(m0.wstrb), .rvalid_o(m0.rvalid),
      .rdata_o(m0.rdata), .rerror_o(m0.rerror), .reg_req_o(q0), .reg_rsp_i(rsp), .timeout_o(to0));

   chimera_mem_to_reg #(.TimeoutCycles(T1)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(m1.req), .gnt_o(m1.gnt), .we_i(m1.we),
      .addr_i(m1.addr), .wdata_i(m1.wdata), .wstrb_i(m1.wstrb), .rvalid_o(m1.rvalid),
      .rdata_o(m1.rdata), .rerror_o(m1.rerror), .reg_req_o(q1), .reg_rsp_i(rsp), .timeout_o(to1));

   int checks = 0;
   int errors = 0;

   // transaction model: one outstanding access per bridge, aged in cycles
   int          tmo [2] = '{T0, T1};
   bit          busy [2];
   int          age [2];
   logic        mwe [2];
   logic [31:0] maddr [2], mwdata [2];
   logic [3:0]  mwstrb [2];
   logic        ov [2], oerr [2], oto [2];
   logic [31:0] odata [2];

   logic        d_rstn = 1'b0;
   logic        d_req;

   logic        s_gnt [2], s_rv [2], s_err [2], s_to [2];
   logic [31:0] s_rd [2];
   reg_req_t    s_q [2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         busy[k] = 1'b0; age[k] = 0; ov[k] = 1'b0; oerr[k] = 1'b0; oto[k] = 1'b0; odata[k] = '0;
      end
   endtask

   function automatic reg_req_t exp_req(input int k);
      reg_req_t e;
      e = '0;
      if (busy[k]) begin
         e.valid = 1'b1; e.write = mwe[k]; e.addr = maddr[k]; e.wdata = mwdata[k]; e.wstrb = mwstrb[k];
      end
      return e;
   endfunction

   task automatic sample();
      s_gnt[0] = m0.gnt; s_rv[0] = m0.rvalid; s_rd[0] = m0.rdata; s_err[0] = m0.rerror; s_to[0] = to0; s_q[0] = q0;
      s_gnt[1] = m1.gnt; s_rv[1] = m1.rvalid; s_rd[1] = m1.rdata; s_err[1] = m1.rerror; s_to[1] = to1; s_q[1] = q1;
   endtask

   task automatic compare(input int k);
      chk($sformatf("gnt%0d", k), 128'(s_gnt[k]), 128'(d_req && !busy[k]));
      chk($sformatf("regreq%0d", k), 128'(s_q[k]), 128'(exp_req(k)));
      chk($sformatf("rvalid%0d", k), 128'(s_rv[k]), 128'(ov[k]));
      chk($sformatf("rdata%0d", k), 128'(s_rd[k]), 128'(odata[k]));
      chk($sformatf("rerror%0d", k), 128'(s_err[k]), 128'(oerr[k]));
      chk($sformatf("timeout%0d", k), 128'(s_to[k]), 128'(oto[k]));
   endtask

   task automatic update(input int k);
      ov[k] = 1'b0; oerr[k] = 1'b0; oto[k] = 1'b0; odata[k] = '0;
      if (busy[k]) begin
         if (rsp.ready) begin
            ov[k] = 1'b1; odata[k] = mwe[k] ? 32'h0 : rsp.rdata; oerr[k] = rsp.error; busy[k] = 1'b0;
         end else if (tmo[k] != 0 && age[k] == tmo[k] - 1) begin
            ov[k] = 1'b1; oerr[k] = 1'b1; oto[k] = 1'b1; busy[k] = 1'b0;
         end else begin
            age[k]++;
         end
      end else if (d_req) begin
         busy[k] = 1'b1; age[k] = 0;
         mwe[k] = m0.we; maddr[k] = m0.addr; mwdata[k] = m0.wdata; mwstrb[k] = m0.wstrb;
      end
   endtask

   task automatic step(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic rdy, input logic [31:0] rd, input logic er);
      @(negedge clk);
      rst_n = d_rstn;
      d_req = req;
      m0.req = req; m0.we = we; m0.addr = addr; m0.wdata = wdata; m0.wstrb = wstrb;
      m1.req = req; m1.we = we; m1.addr = addr; m1.wdata = wdata; m1.wstrb = wstrb;
      rsp.ready = rdy; rsp.rdata = rd; rsp.error = er;
      #1;
      sample();
      compare(0);
      compare(1);
      @(posedge clk);
      if (!rst_n) model_clear();
      else begin
         update(0);
         update(1);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
   endtask

   reg_req_t lit_w;
   int       gnt_exp [7] = '{1, 0, 1, 0, 1, 0, 0};
   int       rv_exp  [7] = '{0, 0, 1, 0, 1, 0, 1};

   initial begin
      d_req = 1'b0;
      rsp = '0;
      m0.req = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.wdata = '0; m0.wstrb = '0;
      m1.req = 1'b0; m1.we = 1'b0; m1.addr = '0; m1.wdata = '0; m1.wstrb = '0;
      model_clear();

      // reset state: outputs cleared, gnt follows req
      step(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1234, 1'b1);
      chk("rst_gnt", 128'(s_gnt[0]), 128'(1));
      chk("rst_valid", 128'(s_q[0]), 128'(0));
      chk("rst_rvalid", 128'(s_rv[0]), 128'(0));
      d_rstn = 1'b1;
      idle();

      // single read, ready in first access cycle
      step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      chk("rd_gnt", 128'(s_gnt[0]), 128'(1));
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      chk("rd_valid", 128'(s_q[0].valid), 128'(1));
      chk("rd_addr", 128'(s_q[0].addr), 128'(32'h100));
      idle();
      chk("rd_rvalid", 128'(s_rv[0]), 128'(1));
      chk("rd_rdata", 128'(s_rd[0]), 128'(32'hDEADBEEF));
      chk("rd_rerror", 128'(s_err[0]), 128'(0));
      idle();
      chk("rd_pulse", 128'(s_rv[0]), 128'(0));

      // write with 3 wait cycles: bus fields stable for 4 cycles
      lit_w = '{valid: 1'b1, write: 1'b1, addr: 32'h200, wdata: 32'hCAFEF00D, wstrb: 4'hF};
      step(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, c == 3, 32'h77777777, 1'b0);
         chk($sformatf("wr_fields%0d", c), 128'(s_q[1]), 128'(lit_w));
      end
      idle();
      chk("wr_rvalid", 128'(s_rv[1]), 128'(1));
      chk("wr_rerror", 128'(s_err[1]), 128'(0));
      chk("wr_rdata", 128'(s_rd[1]), 128'(0));
      idle();

      // ready in the same cycle the timeout would fire: normal response wins
      step(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, c == 3, 32'hA5A5A5A5, 1'b1);
      idle();
      chk("race_rvalid", 128'(s_rv[0]), 128'(1));
      chk("race_rerror", 128'(s_err[0]), 128'(1));
      chk("race_rdata", 128'(s_rd[0]), 128'(32'hA5A5A5A5));
      chk("race_timeout", 128'(s_to[0]), 128'(0));
      idle();

      // ready never comes: timeout-4 bridge aborts, disabled bridge keeps waiting
      step(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         idle();
         chk($sformatf("to_valid%0d", c), 128'(s_q[0].valid), 128'(1));
      end
      idle();
      chk("to_valid_drop", 128'(s_q[0].valid), 128'(0));
      chk("to_pulse", 128'(s_to[0]), 128'(1));
      chk("to_rvalid", 128'(s_rv[0]), 128'(1));
      chk("to_rerror", 128'(s_err[0]), 128'(1));
      chk("to_rdata", 128'(s_rd[0]), 128'(0));
      chk("notmo_valid", 128'(s_q[1].valid), 128'(1));
      chk("notmo_timeout", 128'(s_to[1]), 128'(0));
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
      idle();
      idle();

      // back-to-back reads, one access every 2 cycles
      for (int c = 0; c < 7; c++) begin
         step(c < 5, 1'b0, 32'h500 + 32'(c), 32'h0, 4'h0, c % 2 == 1, 32'h1000 + 32'(c), 1'b0);
         chk($sformatf("b2b_gnt%0d", c), 128'(s_gnt[0]), 128'(gnt_exp[c]));
         chk($sformatf("b2b_rv%0d", c), 128'(s_rv[0]), 128'(rv_exp[c]));
      end
      idle();

      // asynchronous reset in the middle of an access
      step(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      d_rstn = 1'b0;
      #1;
      chk("arst_valid0", 128'(q0.valid), 128'(0));
      chk("arst_valid1", 128'(q1.valid), 128'(0));
      model_clear();
      idle();
      chk("arst_rvalid", 128'(s_rv[0]), 128'(0));
      d_rstn = 1'b1;
      step(1'b1, 1'b0, 32'h604, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h5555AAAA, 1'b0);
      idle();
      chk("post_rvalid", 128'(s_rv[0]), 128'(1));
      chk("post_rdata", 128'(s_rd[0]), 128'(32'h5555AAAA));

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
